pb_autorepeat: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/pb_sync2.sv | 23 ++
 rtl/pb_autorepeat.sv | 111 +++++++++++
 tb/tb_pb_autorepeat.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the operand-entry path: FSM encodings and default timings.
package alu_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_HOLD = 2'd1;
    localparam logic [1:0] ST_REPEAT    = 2'd2;

    localparam int HOLD_MS_DEF   = 500;
    localparam int REPEAT_MS_DEF = 100;

    // Width of a counter that must hold 0 .. max(hold, repeat)-1, never narrower than 1 bit.
    function automatic int ms_cnt_width(input int hold_ms, input int repeat_ms);
        int max_ms;
        max_ms = (hold_ms > repeat_ms) ? hold_ms : repeat_ms;
        return (max_ms > 1) ? $clog2(max_ms) : 1;
    endfunction

endpackage

// File: rtl/pb_sync2.sv
// Two-flop synchronizer bringing a single asynchronous level into the clk domain.
module pb_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the two flops a true shift chain;
            // blocking here would collapse them into one stage.
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pb_autorepeat.sv
// Push-button press/auto-repeat pulse generator driving a wrapping operand counter.
module pb_autorepeat
    import alu_pkg::*;
#(
    parameter int HOLD_MS   = HOLD_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_level,
    input  logic             tick_ms,
    input  logic             clr,
    output logic             press_pulse,
    output logic             repeat_active,
    output logic [CNT_W-1:0] value
);

    localparam int MS_W = ms_cnt_width(HOLD_MS, REPEAT_MS);
    localparam logic [MS_W-1:0] HOLD_LAST   = MS_W'(HOLD_MS - 1);
    localparam logic [MS_W-1:0] REPEAT_LAST = MS_W'(REPEAT_MS - 1);

    logic            s2;
    logic            s3;
    logic            rise;
    logic            held;
    logic [1:0]      state;
    logic [MS_W-1:0] ms_cnt;

    pb_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pb_level),
        .q   (s2)
    );

    assign rise = s2 & ~s3;
    assign held = s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3            <= 1'b0;
            state         <= ST_IDLE;
            ms_cnt        <= '0;
            press_pulse   <= 1'b0;
            repeat_active <= 1'b0;
        end else begin
            s3 <= s2;
            // NOTE: defaulting the pulse low every cycle is what keeps it one cycle wide;
            // the branches below only ever raise it.
            press_pulse <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        ms_cnt      <= '0;
                        state       <= ST_WAIT_HOLD;
                    end
                end

                ST_WAIT_HOLD: begin
                    if (!held) begin
                        ms_cnt <= '0;
                        state  <= ST_IDLE;
                    end else if (tick_ms) begin
                        if (ms_cnt == HOLD_LAST) begin
                            press_pulse   <= 1'b1;
                            ms_cnt        <= '0;
                            repeat_active <= 1'b1;
                            state         <= ST_REPEAT;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end

                // Release is tested before the tick so a coincident terminal tick is dropped.
                ST_REPEAT: begin
                    if (!held) begin
                        ms_cnt        <= '0;
                        repeat_active <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (tick_ms) begin
                        if (ms_cnt == REPEAT_LAST) begin
                            press_pulse <= 1'b1;
                            ms_cnt      <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    ms_cnt        <= '0;
                    repeat_active <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (press_pulse) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: tb/tb_pb_autorepeat.sv
// Directed bench for pb_autorepeat with HOLD_MS=4, REPEAT_MS=2, CNT_W=4 and a tick every 10 clk.
module tb_pb_autorepeat;

    logic       clk;
    logic       rst;
    logic       pb_level;
    logic       tick_ms;
    logic       clr;
    logic       press_pulse;
    logic       repeat_active;
    logic [3:0] value;

    int n_vec;
    int n_miss;
    int edge_no;
    int tick_div;
    int back_to_back;
    bit prev_pulse;
    bit ra_seen;
    int pulse_edges[$];

    pb_autorepeat #(
        .HOLD_MS   (4),
        .REPEAT_MS (2),
        .CNT_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pb_level      (pb_level),
        .tick_ms       (tick_ms),
        .clr           (clr),
        .press_pulse   (press_pulse),
        .repeat_active (repeat_active),
        .value         (value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Advance n clock edges; ticks fire on every 10th edge of the current scenario.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms  = (tick_div == 9);
            tick_div = (tick_div == 9) ? 0 : tick_div + 1;
            @(posedge clk);
            #1;
            edge_no++;
            if (repeat_active) ra_seen = 1'b1;
            if (press_pulse) begin
                pulse_edges.push_back(edge_no);
                if (prev_pulse) back_to_back++;
            end
            prev_pulse = press_pulse;
        end
    endtask

    task automatic begin_scn();
        edge_no  = 0;
        tick_div = 0;
        ra_seen  = 1'b0;
        pulse_edges.delete();
    endtask

    function automatic int pulse_at(input int idx);
        return (idx < pulse_edges.size()) ? pulse_edges[idx] : -1;
    endfunction

    task automatic clear_value();
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
    endtask

    task automatic short_press();
        pb_level = 1'b1;
        cycles(5);
        pb_level = 1'b0;
        cycles(5);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        edge_no      = 0;
        tick_div     = 0;
        back_to_back = 0;
        prev_pulse   = 1'b0;
        ra_seen      = 1'b0;
        rst          = 1'b1;
        pb_level     = 1'b0;
        tick_ms      = 1'b0;
        clr          = 1'b0;

        cycles(3);
        check("reset_pulse", press_pulse, 0);
        check("reset_repeat", repeat_active, 0);
        check("reset_value", value, 0);
        rst = 1'b0;
        cycles(5);

        // Short press: one pulse 3 edges after the rise, no auto-repeat.
        begin_scn();
        pb_level = 1'b1;
        cycles(20);
        pb_level = 1'b0;
        cycles(20);
        check("short_count", pulse_edges.size(), 1);
        check("short_latency", pulse_at(0), 3);
        check("short_value", value, 1);
        check("short_no_repeat", ra_seen, 0);

        // Long hold: pulses at 3, 40 (4th tick), then every 2nd tick: 60, 80, 100.
        clear_value();
        begin_scn();
        pb_level = 1'b1;
        cycles(40);
        check("long_hold_pulse", pulse_at(1), 40);
        check("long_repeat_on", repeat_active, 1);
        cycles(60);
        pb_level = 1'b0;
        cycles(20);
        check("long_count", pulse_edges.size(), 5);
        check("long_rep1", pulse_at(2), 60);
        check("long_rep3", pulse_at(4), 100);
        check("long_value", value, 5);
        check("long_repeat_off", repeat_active, 0);

        // Release seen by the FSM on the same edge as the terminal tick at 80.
        clear_value();
        begin_scn();
        pb_level = 1'b1;
        cycles(77);
        pb_level = 1'b0;
        cycles(2);
        check("coinc_value_before", value, 3);
        check("coinc_repeat_before", repeat_active, 1);
        cycles(1);
        check("coinc_no_pulse", press_pulse, 0);
        check("coinc_repeat_off", repeat_active, 0);
        cycles(20);
        check("coinc_count", pulse_edges.size(), 3);
        check("coinc_value_after", value, 3);

        // Wrap from 15 to 0, then clear beating a coincident pulse.
        clear_value();
        check("wrap_cleared", value, 0);
        for (int i = 0; i < 15; i++) short_press();
        check("wrap_at_15", value, 15);
        short_press();
        check("wrap_to_0", value, 0);
        short_press();
        check("pre_clr_value", value, 1);
        begin_scn();
        pb_level = 1'b1;
        cycles(3);
        check("clr_pulse_present", press_pulse, 1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check("clr_beats_pulse", value, 0);
        cycles(2);
        pb_level = 1'b0;
        cycles(10);
        check("clr_value_after", value, 0);

        // Reset while repeating with the button still held.
        clear_value();
        begin_scn();
        pb_level = 1'b1;
        cycles(45);
        check("rst_mid_repeat_on", repeat_active, 1);
        check("rst_mid_value_pre", value, 2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("rst_mid_pulse", press_pulse, 0);
        check("rst_mid_repeat", repeat_active, 0);
        check("rst_mid_value", value, 0);
        cycles(3);
        check("rst_new_pulse", press_pulse, 1);
        check("rst_new_pulse_edge", pulse_at(2), 49);
        cycles(30);
        check("rst_no_early_repeat", pulse_edges.size(), 3);
        check("rst_wait_hold", repeat_active, 0);
        cycles(1);
        check("rst_hold_pulse", press_pulse, 1);
        check("rst_hold_repeat", repeat_active, 1);
        pb_level = 1'b0;
        cycles(20);

        // Re-press during WAIT_HOLD restarts the full hold delay.
        clear_value();
        begin_scn();
        pb_level = 1'b1;
        cycles(20);
        pb_level = 1'b0;
        cycles(5);
        pb_level = 1'b1;
        cycles(34);
        check("repress_count", pulse_edges.size(), 2);
        check("repress_edge", pulse_at(1), 28);
        check("repress_wait", repeat_active, 0);
        cycles(1);
        check("repress_hold_pulse", press_pulse, 1);
        check("repress_repeat_on", repeat_active, 1);
        pb_level = 1'b0;
        cycles(20);
        check("repress_value", value, 3);

        check("no_back_to_back", back_to_back, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
